// File: rtl/reg_file_pkg.sv
// Shared types for the register file: bus field types and the pending-counter
// update rule used by the scoreboard.
`ifndef SIZE_DATA
`define SIZE_DATA 16
`endif
`ifndef SIZE_TGT_GP
`define SIZE_TGT_GP 4
`endif
`ifndef SIZE_TGT_SR
`define SIZE_TGT_SR 2
`endif

package reg_file_pkg;

  localparam int DATA_W = `SIZE_DATA;
  localparam int GP_AW  = `SIZE_TGT_GP;
  localparam int SR_AW  = `SIZE_TGT_SR;

  typedef logic [DATA_W-1:0] data_t;
  typedef logic [GP_AW-1:0]  gp_addr_t;
  typedef logic [SR_AW-1:0]  sr_addr_t;

  typedef enum logic [1:0] {
    PEND_HOLD,
    PEND_INC,
    PEND_DEC
  } pend_op_e;

  // An issue and a writeback hitting the same register in one cycle cancel out.
  function automatic pend_op_e pend_op(input logic issue_hit, input logic write_hit);
    pend_op_e op;
    op = PEND_HOLD;
    if (issue_hit && !write_hit)      op = PEND_INC;
    else if (write_hit && !issue_hit) op = PEND_DEC;
    return op;
  endfunction

endpackage

// File: rtl/reg_file_if.sv
// Bundle of writeback, read, and issue-tracking signals between the pipeline
// stages (master) and the register file (slave).
interface reg_file_if;
  import reg_file_pkg::*;

  gp_addr_t iw_gp_write_addr;
  data_t    iw_gp_write_data;
  logic     iw_gp_write_enable;

  sr_addr_t iw_sr_write_addr;
  data_t    iw_sr_write_data;
  logic     iw_sr_write_enable;

  gp_addr_t iw_gp_read_addr_a;
  gp_addr_t iw_gp_read_addr_b;
  data_t    ow_gp_read_data_a;
  data_t    ow_gp_read_data_b;

  sr_addr_t iw_sr_read_addr;
  data_t    ow_sr_read_data;

  gp_addr_t iw_issue_gp_tgt;
  logic     iw_issue_gp_we;

  logic     ow_busy_a;
  logic     ow_busy_b;
  logic     ow_issue_stall;

  modport master (
    output iw_gp_write_addr, iw_gp_write_data, iw_gp_write_enable,
    output iw_sr_write_addr, iw_sr_write_data, iw_sr_write_enable,
    output iw_gp_read_addr_a, iw_gp_read_addr_b, iw_sr_read_addr,
    output iw_issue_gp_tgt, iw_issue_gp_we,
    input  ow_gp_read_data_a, ow_gp_read_data_b, ow_sr_read_data,
    input  ow_busy_a, ow_busy_b, ow_issue_stall
  );

  modport slave (
    input  iw_gp_write_addr, iw_gp_write_data, iw_gp_write_enable,
    input  iw_sr_write_addr, iw_sr_write_data, iw_sr_write_enable,
    input  iw_gp_read_addr_a, iw_gp_read_addr_b, iw_sr_read_addr,
    input  iw_issue_gp_tgt, iw_issue_gp_we,
    output ow_gp_read_data_a, ow_gp_read_data_b, ow_sr_read_data,
    output ow_busy_a, ow_busy_b, ow_issue_stall
  );

endinterface

// File: rtl/reg_file_pend_scoreboard.sv
// Per-GP-register saturating count of issued-but-not-written-back instructions,
// with hazard (busy) and issue-stall lookups.
module pend_scoreboard
  import reg_file_pkg::*;
#(
  parameter int ENTRIES = 2**`SIZE_TGT_GP,
  parameter int PEND_W  = 2
) (
  input  logic     iw_clk,
  input  logic     iw_rst,
  input  gp_addr_t iw_issue_tgt,
  input  logic     iw_issue_we,
  input  gp_addr_t iw_write_addr,
  input  logic     iw_write_en,
  input  gp_addr_t iw_read_addr_a,
  input  gp_addr_t iw_read_addr_b,
  output logic     ow_busy_a,
  output logic     ow_busy_b,
  output logic     ow_issue_stall
);

  localparam logic [PEND_W-1:0] CNT_MAX = '1;
  localparam logic [PEND_W-1:0] CNT_ONE = PEND_W'(1);

  logic [ENTRIES-1:0][PEND_W-1:0] cnt_vec;

  for (genvar i = 0; i < ENTRIES; i++) begin : g_entry
    logic              issue_hit;
    logic              write_hit;
    logic [PEND_W-1:0] cnt;

    assign issue_hit = iw_issue_we && (iw_issue_tgt == gp_addr_t'(i));
    assign write_hit = iw_write_en && (iw_write_addr == gp_addr_t'(i));

    // NOTE: state registers use non-blocking (<=) so every flop samples pre-edge values.
    always_ff @(posedge iw_clk or posedge iw_rst) begin
      if (iw_rst) begin
        cnt <= '0;
      end else begin
        unique case (pend_op(issue_hit, write_hit))
          PEND_INC: if (cnt != CNT_MAX) cnt <= cnt + CNT_ONE;
          PEND_DEC: if (cnt != '0)      cnt <= cnt - CNT_ONE;
          default:  ;
        endcase
      end
    end

    assign cnt_vec[i] = cnt;
  end

  // A write landing this cycle on a register with one outstanding write clears
  // the hazard, because the read bypass already returns the new value.
  function automatic logic busy_for(input gp_addr_t addr);
    logic resolved;
    resolved = iw_write_en && (iw_write_addr == addr) && (cnt_vec[addr] == CNT_ONE);
    return (cnt_vec[addr] != '0) && !resolved;
  endfunction

  assign ow_busy_a      = busy_for(iw_read_addr_a);
  assign ow_busy_b      = busy_for(iw_read_addr_b);
  assign ow_issue_stall = (cnt_vec[iw_issue_tgt] == CNT_MAX);

endmodule

// File: rtl/reg_file.sv
// General-purpose and special register file with same-cycle write bypass and a
// pending-write scoreboard for GP hazard detection.
module reg_file
  import reg_file_pkg::*;
#(
  parameter int GP_COUNT = 2**`SIZE_TGT_GP,
  parameter int SR_COUNT = 2**`SIZE_TGT_SR,
  parameter int PEND_W   = 2
) (
  input  logic        iw_clk,
  input  logic        iw_rst,
  reg_file_if.slave   bus
);

  data_t gp_mem [GP_COUNT];
  data_t sr_mem [SR_COUNT];

  // NOTE: storage is reset explicitly since reads must return 0 while in reset,
  // so these arrays are flops, not a RAM macro.
  always_ff @(posedge iw_clk or posedge iw_rst) begin
    if (iw_rst) begin
      for (int i = 0; i < GP_COUNT; i++) gp_mem[i] <= '0;
    end else if (bus.iw_gp_write_enable) begin
      gp_mem[bus.iw_gp_write_addr] <= bus.iw_gp_write_data;
    end
  end

  always_ff @(posedge iw_clk or posedge iw_rst) begin
    if (iw_rst) begin
      for (int i = 0; i < SR_COUNT; i++) sr_mem[i] <= '0;
    end else if (bus.iw_sr_write_enable) begin
      sr_mem[bus.iw_sr_write_addr] <= bus.iw_sr_write_data;
    end
  end

  assign bus.ow_gp_read_data_a =
    (bus.iw_gp_write_enable && bus.iw_gp_write_addr == bus.iw_gp_read_addr_a)
      ? bus.iw_gp_write_data : gp_mem[bus.iw_gp_read_addr_a];

  assign bus.ow_gp_read_data_b =
    (bus.iw_gp_write_enable && bus.iw_gp_write_addr == bus.iw_gp_read_addr_b)
      ? bus.iw_gp_write_data : gp_mem[bus.iw_gp_read_addr_b];

  assign bus.ow_sr_read_data =
    (bus.iw_sr_write_enable && bus.iw_sr_write_addr == bus.iw_sr_read_addr)
      ? bus.iw_sr_write_data : sr_mem[bus.iw_sr_read_addr];

  pend_scoreboard #(
    .ENTRIES (GP_COUNT),
    .PEND_W  (PEND_W)
  ) u_pend_scoreboard (
    .iw_clk         (iw_clk),
    .iw_rst         (iw_rst),
    .iw_issue_tgt   (bus.iw_issue_gp_tgt),
    .iw_issue_we    (bus.iw_issue_gp_we),
    .iw_write_addr  (bus.iw_gp_write_addr),
    .iw_write_en    (bus.iw_gp_write_enable),
    .iw_read_addr_a (bus.iw_gp_read_addr_a),
    .iw_read_addr_b (bus.iw_gp_read_addr_b),
    .ow_busy_a      (bus.ow_busy_a),
    .ow_busy_b      (bus.ow_busy_b),
    .ow_issue_stall (bus.ow_issue_stall)
  );

endmodule

// File: tb/tb_reg_file.sv
// Self-checking bench for reg_file: directed scenarios plus randomized traffic
// compared against an array-based model of registers and pending counts.
module tb_reg_file;
  import reg_file_pkg::*;

  localparam int GP_N     = 2**GP_AW;
  localparam int SR_N     = 2**SR_AW;
  localparam int PEND_MAX = 3;

  logic iw_clk;
  logic iw_rst;

  reg_file_if bus ();

  reg_file #(.PEND_W(2)) dut (
    .iw_clk (iw_clk),
    .iw_rst (iw_rst),
    .bus    (bus)
  );

  initial begin
    iw_clk = 1'b0;
    forever #5 iw_clk = ~iw_clk;
  end

  int n_vec = 0;
  int n_bad = 0;

  int unsigned gp_m   [GP_N];
  int unsigned sr_m   [SR_N];
  int          pend_m [GP_N];

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic model_clear();
    for (int i = 0; i < GP_N; i++) begin
      gp_m[i]   = 0;
      pend_m[i] = 0;
    end
    for (int i = 0; i < SR_N; i++) sr_m[i] = 0;
  endtask

  task automatic model_clock();
    int  wa;
    int  tg;
    bit  wr;
    bit  iss;
    wa  = int'(bus.iw_gp_write_addr);
    tg  = int'(bus.iw_issue_gp_tgt);
    wr  = bus.iw_gp_write_enable;
    iss = bus.iw_issue_gp_we;
    if (iw_rst) begin
      model_clear();
    end else begin
      if (wr) gp_m[wa] = int'(bus.iw_gp_write_data);
      if (bus.iw_sr_write_enable) sr_m[int'(bus.iw_sr_write_addr)] = int'(bus.iw_sr_write_data);
      if (!(wr && iss && wa == tg)) begin
        if (iss) pend_m[tg] = (pend_m[tg] < PEND_MAX) ? pend_m[tg] + 1 : PEND_MAX;
        if (wr)  pend_m[wa] = (pend_m[wa] > 0) ? pend_m[wa] - 1 : 0;
      end
    end
  endtask

  function automatic int exp_gp(input int ra);
    if (bus.iw_gp_write_enable && int'(bus.iw_gp_write_addr) == ra)
      return int'(bus.iw_gp_write_data);
    return gp_m[ra];
  endfunction

  function automatic bit exp_busy(input int ra);
    bit landing;
    landing = bus.iw_gp_write_enable && int'(bus.iw_gp_write_addr) == ra && pend_m[ra] == 1;
    return (pend_m[ra] != 0) && !landing;
  endfunction

  task automatic check_outputs(input string tag);
    int ra;
    int rb;
    int rs;
    int exp_sr;
    ra = int'(bus.iw_gp_read_addr_a);
    rb = int'(bus.iw_gp_read_addr_b);
    rs = int'(bus.iw_sr_read_addr);
    exp_sr = (bus.iw_sr_write_enable && int'(bus.iw_sr_write_addr) == rs)
             ? int'(bus.iw_sr_write_data) : sr_m[rs];
    check({tag, ".rd_a"},  32'(bus.ow_gp_read_data_a), 32'(exp_gp(ra)));
    check({tag, ".rd_b"},  32'(bus.ow_gp_read_data_b), 32'(exp_gp(rb)));
    check({tag, ".rd_sr"}, 32'(bus.ow_sr_read_data),   32'(exp_sr));
    check({tag, ".busy_a"}, 32'(bus.ow_busy_a), 32'(exp_busy(ra)));
    check({tag, ".busy_b"}, 32'(bus.ow_busy_b), 32'(exp_busy(rb)));
    check({tag, ".stall"},  32'(bus.ow_issue_stall),
          32'(pend_m[int'(bus.iw_issue_gp_tgt)] == PEND_MAX));
  endtask

  // Called just after a falling edge with inputs already driven.
  task automatic tick(input string tag);
    #1;
    check_outputs(tag);
    @(posedge iw_clk);
    model_clock();
    @(negedge iw_clk);
  endtask

  task automatic idle();
    bus.iw_gp_write_addr   = '0;
    bus.iw_gp_write_data   = '0;
    bus.iw_gp_write_enable = 1'b0;
    bus.iw_sr_write_addr   = '0;
    bus.iw_sr_write_data   = '0;
    bus.iw_sr_write_enable = 1'b0;
    bus.iw_gp_read_addr_a  = '0;
    bus.iw_gp_read_addr_b  = '0;
    bus.iw_sr_read_addr    = '0;
    bus.iw_issue_gp_tgt    = '0;
    bus.iw_issue_gp_we     = 1'b0;
  endtask

  task automatic gp_write(input int a, input int d);
    bus.iw_gp_write_enable = 1'b1;
    bus.iw_gp_write_addr   = gp_addr_t'(a);
    bus.iw_gp_write_data   = data_t'(d);
  endtask

  task automatic sr_write(input int a, input int d);
    bus.iw_sr_write_enable = 1'b1;
    bus.iw_sr_write_addr   = sr_addr_t'(a);
    bus.iw_sr_write_data   = data_t'(d);
  endtask

  task automatic issue(input int t);
    bus.iw_issue_gp_we  = 1'b1;
    bus.iw_issue_gp_tgt = gp_addr_t'(t);
  endtask

  task automatic reads(input int a, input int b, input int s);
    bus.iw_gp_read_addr_a = gp_addr_t'(a);
    bus.iw_gp_read_addr_b = gp_addr_t'(b);
    bus.iw_sr_read_addr   = sr_addr_t'(s);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    model_clear();
    idle();
    iw_rst = 1'b1;
    @(negedge iw_clk);

    // Reset state
    reads(3, 5, 2);
    #1;
    check("reset.busy_a", 32'(bus.ow_busy_a), 32'd0);
    check("reset.stall",  32'(bus.ow_issue_stall), 32'd0);
    tick("reset");
    iw_rst = 1'b0;

    // Write then read back from storage
    idle(); gp_write(3, 16'h00A5); tick("w_gp3");
    idle(); reads(3, 0, 0);
    #1; check("gp3.rd_a", 32'(bus.ow_gp_read_data_a), 32'h00A5);
    tick("r_gp3");

    // Disabled write leaves storage alone; enabled write bypasses
    idle(); reads(0, 5, 0);
    bus.iw_gp_write_addr = gp_addr_t'(5);
    bus.iw_gp_write_data = data_t'(16'h1234);
    #1; check("gp5_off.rd_b", 32'(bus.ow_gp_read_data_b), 32'h0);
    tick("gp5_off");
    #1; check("gp5_off_after.rd_b", 32'(bus.ow_gp_read_data_b), 32'h0);
    gp_write(5, 16'h1234);
    #1; check("gp5_byp.rd_b", 32'(bus.ow_gp_read_data_b), 32'h1234);
    tick("gp5_byp");

    // Two outstanding writes to GP7
    idle(); issue(7); tick("iss7_a"); tick("iss7_b");
    idle(); reads(7, 7, 0); gp_write(7, 16'h0111);
    #1; check("gp7_wr1.busy_a", 32'(bus.ow_busy_a), 32'd1);
    tick("gp7_wr1");
    idle(); reads(7, 0, 0);
    #1; check("gp7_mid.busy_a", 32'(bus.ow_busy_a), 32'd1);
    tick("gp7_mid");
    gp_write(7, 16'h0222);
    #1; check("gp7_wr2.busy_a", 32'(bus.ow_busy_a), 32'd0);
    tick("gp7_wr2");
    idle(); reads(7, 0, 0);
    #1; check("gp7_done.busy_a", 32'(bus.ow_busy_a), 32'd0);
    tick("gp7_done");

    // Saturation of GP2's counter
    idle(); reads(2, 0, 0); issue(2);
    for (int i = 0; i < 3; i++) begin
      #1; check($sformatf("gp2_iss%0d.stall", i), 32'(bus.ow_issue_stall), 32'd0);
      tick("gp2_iss");
    end
    #1; check("gp2_iss3.stall", 32'(bus.ow_issue_stall), 32'd1);
    tick("gp2_sat");
    bus.iw_issue_gp_we = 1'b0;
    for (int i = 0; i < 3; i++) begin
      gp_write(2, 16'h0200 + i);
      #1; check($sformatf("gp2_wr%0d.busy_a", i), 32'(bus.ow_busy_a), (i < 2) ? 32'd1 : 32'd0);
      tick("gp2_wr");
    end
    idle(); reads(2, 0, 0); bus.iw_issue_gp_tgt = gp_addr_t'(2);
    #1; check("gp2_empty.busy_a", 32'(bus.ow_busy_a), 32'd0);
    check("gp2_empty.stall", 32'(bus.ow_issue_stall), 32'd0);
    tick("gp2_empty");

    // Issue and write to the same register cancel
    idle(); reads(9, 0, 0); issue(9); tick("gp9_iss");
    gp_write(9, 16'h0999); tick("gp9_both");
    idle(); reads(9, 0, 0);
    #1; check("gp9_hold.busy_a", 32'(bus.ow_busy_a), 32'd1);
    tick("gp9_hold");
    gp_write(9, 16'h0998); tick("gp9_drain");

    // Randomized traffic, addresses biased toward a few registers for collisions
    for (int n = 0; n < 400; n++) begin
      int span;
      idle();
      span = ($urandom_range(0, 1) == 1) ? 3 : GP_N - 1;
      bus.iw_gp_write_enable = 1'($urandom_range(0, 1));
      bus.iw_gp_write_addr   = gp_addr_t'($urandom_range(0, span));
      bus.iw_gp_write_data   = data_t'($urandom);
      bus.iw_sr_write_enable = 1'($urandom_range(0, 1));
      bus.iw_sr_write_addr   = sr_addr_t'($urandom_range(0, SR_N - 1));
      bus.iw_sr_write_data   = data_t'($urandom);
      bus.iw_issue_gp_we     = 1'($urandom_range(0, 2) != 0);
      bus.iw_issue_gp_tgt    = gp_addr_t'($urandom_range(0, span));
      reads($urandom_range(0, span), $urandom_range(0, span), $urandom_range(0, SR_N - 1));
      tick("rnd");
    end

    // Reset in the middle of activity, observed without a clock edge
    idle(); gp_write(1, 16'hFFFF); sr_write(2, 16'h0042); issue(4); tick("pre_rst_a");
    idle(); issue(4); tick("pre_rst_b"); tick("pre_rst_c");
    idle(); reads(1, 4, 2); bus.iw_issue_gp_tgt = gp_addr_t'(4);
    #1; check("pre_rst.rd_a",  32'(bus.ow_gp_read_data_a), 32'hFFFF);
    check("pre_rst.rd_sr", 32'(bus.ow_sr_read_data), 32'h0042);
    check("pre_rst.stall", 32'(bus.ow_issue_stall), 32'd1);
    iw_rst = 1'b1;
    model_clear();
    #1; check("mid_rst.rd_a",   32'(bus.ow_gp_read_data_a), 32'h0);
    check("mid_rst.rd_sr",  32'(bus.ow_sr_read_data), 32'h0);
    check("mid_rst.busy_b", 32'(bus.ow_busy_b), 32'd0);
    check("mid_rst.stall",  32'(bus.ow_issue_stall), 32'd0);
    gp_write(6, 16'hBEEF); issue(6);
    tick("rst_edge");
    iw_rst = 1'b0;
    idle(); reads(6, 1, 2); bus.iw_issue_gp_tgt = gp_addr_t'(6);
    #1; check("post_rst.rd_a",   32'(bus.ow_gp_read_data_a), 32'h0);
    check("post_rst.busy_a", 32'(bus.ow_busy_a), 32'd0);
    tick("post_rst");

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule

// File: doc/reg_file.md
REG_FILE -- requirements
Module: reg_file

Interface
REQ-001 Parameter GP_COUNT, default 2**`SIZE_TGT_GP, sets the number of general-purpose registers.
REQ-002 Parameter SR_COUNT, default 2**`SIZE_TGT_SR, sets the number of special registers.
REQ-003 Parameter PEND_W, default 2, sets the width of each per-register pending-write counter.
REQ-004 iw_clk  in  1  is the single clock; all state updates on its rising edge.
REQ-005 iw_rst  in  1  is the reset, asynchronous and active-high.
REQ-006 iw_gp_write_addr / iw_gp_write_data / iw_gp_write_enable  in  `SIZE_TGT_GP / `SIZE_DATA / 1  form the GP writeback port, driven by the writeback stage.
REQ-007 iw_sr_write_addr / iw_sr_write_data / iw_sr_write_enable  in  `SIZE_TGT_SR / `SIZE_DATA / 1  form the SR writeback port.
REQ-008 iw_gp_read_addr_a, iw_gp_read_addr_b  in  `SIZE_TGT_GP  are the decode-stage GP source selects.
REQ-009 ow_gp_read_data_a, ow_gp_read_data_b  out  `SIZE_DATA  return the GP read data.
REQ-010 iw_sr_read_addr  in  `SIZE_TGT_SR  and ow_sr_read_data  out  `SIZE_DATA  form the SR read port.
REQ-011 iw_issue_gp_tgt  in  `SIZE_TGT_GP  and iw_issue_gp_we  in  1  mark issue of an instruction that will later write that GP register.
REQ-012 ow_busy_a, ow_busy_b  out  1  are high when the corresponding read address has an outstanding write.
REQ-013 ow_issue_stall  out  1  is high when the issue target's pending counter is saturated.

Function
REQ-014 GP and SR reads shall be combinational from storage, with a same-cycle bypass: if the write enable is high and the write address equals the read address, the read returns the write data.
REQ-015 A GP write with enable high shall update the addressed register at the rising edge; SR writes behave likewise.
REQ-016 A write with enable low shall leave all storage unchanged, whatever the address and data values.
REQ-017 Each GP register shall have a PEND_W-bit pending counter.
REQ-018 The counter shall be incremented on issue (iw_issue_gp_we) and decremented on a GP write to the same register.
REQ-019 When issue and write target the same register in the same cycle, the counter shall stay unchanged.
REQ-020 When issue and write target different registers, each counter shall be updated independently in the same cycle.
REQ-021 ow_busy_x shall be high when counter[addr] != 0 and the register is not being written this cycle with counter == 1 (bypass resolves the hazard).
REQ-022 ow_issue_stall shall be high when counter[iw_issue_gp_tgt] is at its maximum value; an increment while saturated shall be ignored (the counter never wraps).
REQ-023 A decrement at counter 0 shall be ignored (the counter never wraps); the write data is still stored.
REQ-024 Read and write latency: the bypass gives zero cycles; a write is visible from storage one cycle after the write edge.

Reset
REQ-025 While iw_rst is high, all GP registers, SR registers and pending counters shall be 0.
REQ-026 While iw_rst is high, ow_busy_a, ow_busy_b and ow_issue_stall shall be 0.
REQ-027 Read data outputs shall show 0 during reset unless the bypass condition is active.
REQ-028 Reset asserted in the middle of an operation shall discard all pending counts and any write presented on that edge.

Structure
REQ-029 `SIZE_DATA, `SIZE_TGT_GP and `SIZE_TGT_SR shall come from the shared sizes header; the block shall add no new global constants.
REQ-030 The pending counters shall live in one sub-module, pend_scoreboard, instantiated once with GP_COUNT entries.

Verification
REQ-031 Write GP3=0x00A5 with enable high, then read addr_a=3 next cycle -> ow_gp_read_data_a=0x00A5.
REQ-032 Write GP5=0x1234 while reading addr_b=5 in the same cycle -> ow_gp_read_data_b=0x1234 (bypass); the same write with enable low -> 0.
REQ-033 Issue GP7 twice, then write GP7 once -> ow_busy_a for addr 7 is 1 throughout the write cycle; after two writes, busy=0.
REQ-034 Issue GP2 three times with PEND_W=2 -> stall=0, 0, 0, then a fourth issue shows stall=1 and the counter holds at 3.
REQ-035 Issue and write GP9 in the same cycle with counter=1 -> the counter remains 1.
REQ-036 Assert reset mid-sequence with GP1=0xFFFF and SR2=0x0042 -> all reads return 0, busy and stall are 0, and no clock edge is required for this.
